ram_bank_pipe: RTL and testbench
================================

Name: ram_bank_pipe

Overview:
Parametrised simple-dual-port RAM bank: one write port and one read port on a single clock. It adds byte-lane write enables, a configurable read-latency pipeline with a read-valid strobe, and a selectable read/write collision mode. An optional zero-initialisation sweep runs after reset, with a busy flag. It is the drop-in successor bank for datapath scratch storage.

Parameters:
ADDR_BIT, 3, address width of both ports
DATA_BIT, 16, word width; must be a multiple of LANE_BIT
MEM_HEIGHT, 8, number of words; 1..2**ADDR_BIT
LANE_BIT, 8, bits per byte-enable lane; NUM_LANES = DATA_BIT/LANE_BIT
RD_LAT, 1, read latency in cycles; legal range 1..4
WR_FIRST, 1, 1 = a colliding read returns the new data; 0 = it returns the old data
INIT_ON_RST, 1, 1 = zero all words after reset

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
en  in  1  global enable for both ports
we  in  1  write request
be  in  NUM_LANES  byte-lane write enables; lane i = d_w[i*LANE_BIT +: LANE_BIT]
addr_w  in  ADDR_BIT  write address
d_w  in  DATA_BIT  write data
re  in  1  read request
addr_r  in  ADDR_BIT  read address
d_r  out  DATA_BIT  read data
rd_valid  out  1  d_r carries the result of an accepted read
busy  out  1  init sweep in progress; requests ignored

Behaviour:
- Reset: one clock, synchronous, active-high. On any edge with rst=1:
  - d_r=0, rd_valid=0, read pipeline flushed.
  - With INIT_ON_RST=1: FSM to ST_INIT, sweep counter=0, busy=1.
  - With INIT_ON_RST=0: FSM to ST_IDLE, busy=0, memory contents retained.
- Reset mid-sweep restarts the sweep from address 0. Reset flushes any in-flight reads; their rd_valid never asserts.
- FSM states:
  - ST_INIT: each edge writes 0 to word cnt and increments cnt. After the write of MEM_HEIGHT-1 → ST_IDLE, busy=0 from that edge. busy is therefore high for exactly MEM_HEIGHT cycles after rst falls.
  - ST_IDLE: normal operation.
- Write: on an edge with en & we & !busy & addr_w<MEM_HEIGHT, mem[addr_w] lanes with be[i]=1 take d_w; the other lanes are unchanged. be=0 writes nothing. An out-of-range write is dropped.
- Read accept: on edge k with en & re & !busy. The result appears on d_r with rd_valid=1 after edge k+RD_LAT-1. With RD_LAT=1, d_r is registered at edge k itself.
- Reads are fully pipelined: one accept per cycle, back-to-back, and results return in order.
- An out-of-range read returns 0 with rd_valid=1.
- Non-accepting cycles (en=0, re=0 or busy) inject a bubble. rd_valid=0 for that slot; d_r holds its last value.
- The pipeline advances every cycle regardless of en.
- Collision (same edge accepts a write and a read to the same in-range address):
  - WR_FIRST=1: the read returns the merged word — new data in enabled lanes, old data elsewhere.
  - WR_FIRST=0: the read returns the pre-write word.
- Requests arriving while busy are ignored with no queuing.
- Widths: the comparison addr<MEM_HEIGHT uses ADDR_BIT+1 bits. When MEM_HEIGHT=2**ADDR_BIT, no address is out of range.
- Illegal parameters (DATA_BIT % LANE_BIT ≠ 0, RD_LAT outside 1..4, MEM_HEIGHT>2**ADDR_BIT) stop elaboration via a generate-time error.

Decomposition:
- ram_bank_pkg:
  - FSM enum {ST_INIT, ST_IDLE}
  - function lane_merge(old, new, be) returning the merged word
  - localparam-style constant MAX_RD_LAT=4
- Sub-module ram_rd_pipe: parametrised (DATA_BIT, RD_LAT) delay line for data+valid, with flush on rst. Stage 0 is the array read register; stages 1..RD_LAT-1 are pass-through flops.

Test Plan:
1. Init sweep (defaults): rst=1 for 2 edges, then 0 → busy=1 for exactly 8 cycles. Then read addr 0..7 → d_r=0x0000 each with rd_valid=1 one edge later. A write issued at addr 2 during busy is not stored; it reads back 0.
2. Fill/readback with RD_LAT=3: write mem[i]=i*0x0101 for i=0..7 with be=2'b11, then back-to-back reads 0..7 → rd_valid rises 2 edges after the first accept and holds for 8 consecutive cycles; d_r=0x0000,0x0101,…,0x0707.
3. Byte enables: mem[5]=0xAAAA; write d_w=0x1234 with be=2'b01 → read 0xAA34. Then write 0x5600 with be=2'b10 → read 0x5634. Write with be=2'b00 → still 0x5634.
4. Collision: mem[3]=0x0003; on the same edge write addr 3 d_w=0x000A be=2'b11 and read addr 3 → d_r=0x000A with WR_FIRST=1, 0x0003 with WR_FIRST=0. A follow-up read returns 0x000A in both modes.
5. Bubbles/enable: alternate re=1/0 at addrs 1,2 with en=1, then en=0 with re=1 → rd_valid pattern 1,0,1,0 then 0. d_r holds the last value.
6. Reset mid-operation: rst pulse at sweep count 4, and separately with 2 reads in flight at RD_LAT=3 → the sweep restarts, giving 8 busy cycles after rst falls. No rd_valid is seen for the flushed reads; d_r=0.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// Shared types and helpers for the pipelined simple-dual-port RAM bank.
package ram_bank_pkg;

  localparam int MAX_RD_LAT   = 4;
  localparam int MAX_DATA_BIT = 64;
  localparam int MAX_LANES    = 64;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  // Callers zero-extend to MAX_DATA_BIT and slice the result back down.
  function automatic logic [MAX_DATA_BIT-1:0] lane_merge(
    input logic [MAX_DATA_BIT-1:0] old_word,
    input logic [MAX_DATA_BIT-1:0] new_word,
    input logic [MAX_LANES-1:0]    be,
    input int                      lane_bit
  );
    logic [MAX_DATA_BIT-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_DATA_BIT; i++) begin
      if (be[i / lane_bit]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_bank_pipe_rd_pipe.sv
// Read-result delay line: stage 0 captures the array word, later stages pass it on.
module ram_rd_pipe #(
  parameter int DATA_BIT = 16,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_BIT-1:0] in_data,
  output logic                out_valid,
  output logic [DATA_BIT-1:0] out_data
);

  logic [RD_LAT-1:0]   vld;
  logic [DATA_BIT-1:0] dat [RD_LAT];

  // Data only moves with a valid slot, so bubbles leave the output word holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/ram_bank_pipe.sv
// Simple-dual-port RAM bank with byte-lane writes, pipelined reads and a post-reset zero sweep.
module ram_bank_pipe
  import ram_bank_pkg::*;
#(
  parameter int ADDR_BIT    = 3,
  parameter int DATA_BIT    = 16,
  parameter int MEM_HEIGHT  = 8,
  parameter int LANE_BIT    = 8,
  parameter int RD_LAT      = 1,
  parameter int WR_FIRST    = 1,
  parameter int INIT_ON_RST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         we,
  input  logic [DATA_BIT/LANE_BIT-1:0] be,
  input  logic [ADDR_BIT-1:0]          addr_w,
  input  logic [DATA_BIT-1:0]          d_w,
  input  logic                         re,
  input  logic [ADDR_BIT-1:0]          addr_r,
  output logic [DATA_BIT-1:0]          d_r,
  output logic                         rd_valid,
  output logic                         busy
);

  if (DATA_BIT % LANE_BIT != 0) begin : g_err_lane
    $error("ram_bank_pipe: DATA_BIT must be a multiple of LANE_BIT");
  end
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_err_lat
    $error("ram_bank_pipe: RD_LAT must be in 1..4");
  end
  if (MEM_HEIGHT < 1 || MEM_HEIGHT > (1 << ADDR_BIT)) begin : g_err_height
    $error("ram_bank_pipe: MEM_HEIGHT must be in 1..2**ADDR_BIT");
  end
  if (DATA_BIT > MAX_DATA_BIT) begin : g_err_width
    $error("ram_bank_pipe: DATA_BIT exceeds MAX_DATA_BIT");
  end

  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(MEM_HEIGHT - 1);
  localparam logic [ADDR_BIT:0]   HEIGHT_X  = (ADDR_BIT+1)'(MEM_HEIGHT);

  state_t                  state, state_nxt;
  logic [ADDR_BIT-1:0]     cnt, cnt_nxt;
  logic [DATA_BIT-1:0]     mem [MEM_HEIGHT];
  logic                    w_in_range, r_in_range, wr_ok, rd_ok;
  logic [DATA_BIT-1:0]     old_w, wr_word, rd_word;
  logic [MAX_DATA_BIT-1:0] merged_full;

  assign busy = (state == ST_INIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (INIT_ON_RST != 0) ? ST_INIT : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Range checks carry one extra bit so MEM_HEIGHT == 2**ADDR_BIT compares correctly.
  assign w_in_range = ({1'b0, addr_w} < HEIGHT_X);
  assign r_in_range = ({1'b0, addr_r} < HEIGHT_X);
  assign wr_ok      = en & we & ~busy & ~rst & w_in_range;
  assign rd_ok      = en & re & ~busy & ~rst;

  always_comb begin
    old_w = '0;
    if (w_in_range) old_w = mem[addr_w];
    merged_full = lane_merge(MAX_DATA_BIT'(old_w), MAX_DATA_BIT'(d_w),
                             MAX_LANES'(be), LANE_BIT);
    wr_word = merged_full[DATA_BIT-1:0];
  end

  // Write-first collisions forward the merged word; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (r_in_range) begin
      if (WR_FIRST != 0 && wr_ok && addr_w == addr_r) rd_word = wr_word;
      else                                           rd_word = mem[addr_r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy)       mem[cnt]    <= '0;
      else if (wr_ok) mem[addr_w] <= wr_word;
    end
  end

  ram_rd_pipe #(
    .DATA_BIT (DATA_BIT),
    .RD_LAT   (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_ok),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (d_r)
  );

endmodule

// File: tb/tb_ram_bank_pipe.sv
// Bench for ram_bank_pipe: defaults, WR_FIRST=0, RD_LAT=3 and MEM_HEIGHT=6 banks share one stimulus.
module tb_ram_bank_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en, we, re;
  logic [1:0]  be;
  logic [2:0]  addr_w, addr_r;
  logic [15:0] d_w;

  logic [15:0] dut_d, wf0_d, lat_d, sml_d;
  logic        dut_v, wf0_v, lat_v, sml_v;
  logic        dut_busy, wf0_busy, lat_busy, sml_busy;

  int tests = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        en, we;
    logic [1:0]  be;
    logic [2:0]  addr_w;
    logic [15:0] d_w;
    logic        re;
    logic [2:0]  addr_r;
    logic        exp_v;
    logic [15:0] exp_d, exp_old, exp_sml;
  } vec_t;
  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ram_bank_pipe u_dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr_w(addr_w), .d_w(d_w),
    .re(re), .addr_r(addr_r), .d_r(dut_d), .rd_valid(dut_v), .busy(dut_busy));

  ram_bank_pipe #(.WR_FIRST(0)) u_wf0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr_w(addr_w), .d_w(d_w),
    .re(re), .addr_r(addr_r), .d_r(wf0_d), .rd_valid(wf0_v), .busy(wf0_busy));

  ram_bank_pipe #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr_w(addr_w), .d_w(d_w),
    .re(re), .addr_r(addr_r), .d_r(lat_d), .rd_valid(lat_v), .busy(lat_busy));

  ram_bank_pipe #(.MEM_HEIGHT(6)) u_small (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr_w(addr_w), .d_w(d_w),
    .re(re), .addr_r(addr_r), .d_r(sml_d), .rd_valid(sml_v), .busy(sml_busy));

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    en = 1'b0; we = 1'b0; be = 2'b00; addr_w = '0; d_w = '0; re = 1'b0; addr_r = '0;
  endtask

  task automatic drive(input logic e, input logic w, input logic [1:0] b, input logic [2:0] aw,
                       input logic [15:0] dw, input logic r, input logic [2:0] ar);
    en = e; we = w; be = b; addr_w = aw; d_w = dw; re = r; addr_r = ar;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic w, input logic [1:0] b,
                              input logic [2:0] aw, input logic [15:0] dw, input logic r,
                              input logic [2:0] ar, input logic v, input logic [15:0] d,
                              input logic [15:0] d_old, input logic [15:0] d_sml);
    vec_t x;
    x.en = e; x.we = w; x.be = b; x.addr_w = aw; x.d_w = dw; x.re = r; x.addr_r = ar;
    x.exp_v = v; x.exp_d = d; x.exp_old = d_old; x.exp_sml = d_sml;
    return x;
  endfunction

  // Steps until both the 8-word and 6-word banks finish their sweeps; optional write/read
  // attack is withdrawn as soon as the small bank leaves busy.
  task automatic wait_sweep(input string tag, input bit attack);
    int n, n_d, n_s;
    bit seen_v;
    n = 0; n_d = 0; n_s = 0; seen_v = 1'b0;
    if (attack) drive(1, 1, 2'b11, 3'd2, 16'hFFFF, 1, 3'd0);
    while ((n_d == 0 || n_s == 0) && n < 20) begin
      step();
      n++;
      if (dut_v || sml_v || lat_v || wf0_v) seen_v = 1'b1;
      if (!dut_busy && n_d == 0) n_d = n;
      if (!sml_busy && n_s == 0) begin
        n_s = n;
        set_idle();
      end
    end
    set_idle();
    check({tag, "_busy_cycles_h8"}, n_d, 8);
    check({tag, "_busy_cycles_h6"}, n_s, 6);
    check({tag, "_no_valid_while_busy"}, seen_v, 0);
  endtask

  initial begin
    logic [15:0] w;
    int t;
    set_idle();

    // Phase 1: reset and init sweep; a write to addr 2 during busy must be dropped.
    rst = 1'b1;
    step();
    step();
    check("rst_d_r", dut_d, 16'h0000);
    check("rst_rd_valid", dut_v, 1'b0);
    check("rst_busy", dut_busy, 1'b1);
    check("rst_busy_small", sml_busy, 1'b1);
    check("rst_lat3_valid", lat_v, 1'b0);
    rst = 1'b0;
    wait_sweep("init", 1'b1);

    // Phase 2: directed vector table (RD_LAT=1 banks).
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 3'(i), 1, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 1, 2'b11, 5, 16'hAAAA, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 1, 2'b01, 5, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 5, 1, 16'hAA34, 16'hAA34, 16'hAA34));
    vecs.push_back(mk(1, 1, 2'b10, 5, 16'h5600, 0, 0, 0, 16'hAA34, 16'hAA34, 16'hAA34));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 5, 1, 16'h5634, 16'h5634, 16'h5634));
    vecs.push_back(mk(1, 1, 2'b00, 5, 16'hFFFF, 0, 0, 0, 16'h5634, 16'h5634, 16'h5634));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 5, 1, 16'h5634, 16'h5634, 16'h5634));
    vecs.push_back(mk(1, 1, 2'b11, 3, 16'h0003, 0, 0, 0, 16'h5634, 16'h5634, 16'h5634));
    vecs.push_back(mk(1, 1, 2'b11, 3, 16'h000A, 1, 3, 1, 16'h000A, 16'h0003, 16'h000A));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 3, 1, 16'h000A, 16'h000A, 16'h000A));
    vecs.push_back(mk(1, 1, 2'b10, 3, 16'hCCDD, 1, 3, 1, 16'hCC0A, 16'h000A, 16'hCC0A));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 3, 1, 16'hCC0A, 16'hCC0A, 16'hCC0A));
    vecs.push_back(mk(1, 1, 2'b11, 6, 16'h7777, 0, 0, 0, 16'hCC0A, 16'hCC0A, 16'hCC0A));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 6, 1, 16'h7777, 16'h7777, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 7, 1, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 1, 2'b11, 1, 16'h1111, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 1, 2'b11, 2, 16'h2222, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 1, 1, 16'h1111, 16'h1111, 16'h1111));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 0, 2, 0, 16'h1111, 16'h1111, 16'h1111));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 2, 1, 16'h2222, 16'h2222, 16'h2222));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 0, 1, 0, 16'h2222, 16'h2222, 16'h2222));
    vecs.push_back(mk(0, 1, 2'b11, 1, 16'hDEAD, 1, 1, 0, 16'h2222, 16'h2222, 16'h2222));
    vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 1, 1, 16'h1111, 16'h1111, 16'h1111));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].be, vecs[i].addr_w, vecs[i].d_w,
            vecs[i].re, vecs[i].addr_r);
      step();
      check($sformatf("vec%0d_valid", i), dut_v, vecs[i].exp_v);
      check($sformatf("vec%0d_d_r", i), dut_d, vecs[i].exp_d);
      check($sformatf("vec%0d_wf0_valid", i), wf0_v, vecs[i].exp_v);
      check($sformatf("vec%0d_wf0_d_r", i), wf0_d, vecs[i].exp_old);
      check($sformatf("vec%0d_small_valid", i), sml_v, vecs[i].exp_v);
      check($sformatf("vec%0d_small_d_r", i), sml_d, vecs[i].exp_sml);
    end
    set_idle();

    // Phase 3: fill, then back-to-back reads; RD_LAT=3 results checked through exp_q.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 2'b11, 3'(i), 16'(i * 16'h0101), 0, 0);
      step();
    end
    for (t = 0; t < 12; t++) begin
      drive(1, 0, 2'b00, 0, 0, (t < 8), 3'(t));
      step();
      if (t < 8) exp_q.push_back(16'(t * 16'h0101));
      check($sformatf("fill_t%0d_valid", t), dut_v, (t < 8));
      check($sformatf("fill_t%0d_d_r", t), dut_d, (t < 8) ? 16'(t * 16'h0101) : 16'h0707);
      check($sformatf("lat3_t%0d_valid", t), lat_v, (t >= 2 && t < 10));
      if (lat_v) begin
        if (exp_q.size() == 0) begin
          check($sformatf("lat3_t%0d_unexpected", t), lat_v, 1'b0);
        end else begin
          w = exp_q.pop_front();
          check($sformatf("lat3_t%0d_d_r", t), lat_d, w);
        end
      end else if (t >= 10) begin
        check($sformatf("lat3_t%0d_hold", t), lat_d, 16'h0707);
      end
    end
    check("lat3_queue_drained", exp_q.size(), 0);
    set_idle();

    // Phase 4a: reset at sweep count 4 restarts the sweep from 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_d_r", dut_d, 16'h0000);
    check("rst2_valid", dut_v, 1'b0);
    repeat (4) step();
    check("midsweep_busy", dut_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_sweep("restart", 1'b0);

    // Phase 4b: two reads in flight in the RD_LAT=3 bank are flushed by reset.
    drive(1, 1, 2'b11, 1, 16'h4242, 0, 0);
    step();
    drive(1, 0, 2'b00, 0, 0, 1, 1);
    step();
    check("pre_flush_d_r", dut_d, 16'h4242);
    step();
    set_idle();
    check("pre_flush_lat3_valid", lat_v, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush_lat3_valid", lat_v, 1'b0);
    check("flush_lat3_d_r", lat_d, 16'h0000);
    check("flush_d_r", dut_d, 16'h0000);
    wait_sweep("flush", 1'b0);
    check("post_flush_lat3_d_r", lat_d, 16'h0000);
    drive(1, 0, 2'b00, 0, 0, 1, 1);
    step();
    set_idle();
    check("reinit_valid", dut_v, 1'b1);
    check("reinit_d_r", dut_d, 16'h0000);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
